pq_cmd_sequencer: RTL and testbench

//  Upstream command stage for the register-array priority queue (ra_pq_s).

---
 rtl/pq_cmd_sequencer_if.sv | 25 ++
 rtl/pq_cmd_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pq_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_cmd_sequencer_if.sv
// Host command channel for pq_cmd_sequencer.
// Valid/ready handshake carrying the op bit and {key,value}.
interface pq_cmd_sequencer_if #(
    parameter int KW = 4,
    parameter int VW = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [KW+VW-1:0]  cmd_kv;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_kv,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_kv,
        output cmd_ready
    );
endinterface

// File: rtl/pq_cmd_sequencer.sv
// Command FIFO and issue FSM in front of the register-array priority queue.
// Illegal ops are dropped in order and counted; dequeued entries are returned.
module pq_cmd_sequencer #(
    parameter int KW         = 4,
    parameter int VW         = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    pq_cmd_sequencer_if.slave   cmd,
    output logic                pq_enq,
    output logic                pq_deq,
    output logic [KW+VW-1:0]    pq_kvi,
    input  logic [KW+VW-1:0]    pq_kvo,
    input  logic                pq_busy,
    input  logic                pq_full,
    input  logic                pq_empty,
    output logic                rsp_valid,
    output logic [KW+VW-1:0]    rsp_kv,
    output logic                err_drop,
    output logic [7:0]          drop_count
);
    localparam int W  = KW + VW;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [W:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    state_t         r_state;
    state_t         w_next;

    logic           r_pq_enq;
    logic           r_pq_deq;
    logic [W-1:0]   r_pq_kvi;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_kv;
    logic           r_err_drop;
    logic [7:0]     r_drop_count;

    logic           w_full;
    logic           w_head_valid;
    logic           w_head_op;
    logic [W-1:0]   w_head_kv;
    logic           w_push;
    logic           w_go;
    logic           w_illegal;
    logic           w_pop;
    logic           w_drop;
    logic           w_issue_enq;
    logic           w_issue_deq;
    logic           w_cap_rsp;

    assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_head_valid = (r_count != '0);
    assign w_head_op    = r_mem[r_rd_ptr][W];
    assign w_head_kv    = r_mem[r_rd_ptr][W-1:0];

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign cmd.cmd_ready = !rst && !w_full;
    assign w_push        = cmd.cmd_valid && cmd.cmd_ready;

    assign w_go      = (r_state == S_IDLE) && w_head_valid && !pq_busy;
    assign w_illegal = w_head_op ? pq_empty : pq_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_kv};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go && !w_illegal) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (!pq_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        w_issue_enq = 1'b0;
        w_issue_deq = 1'b0;
        w_cap_rsp   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_pop       = 1'b1;
                    w_drop      = w_illegal;
                    w_issue_enq = !w_illegal && !w_head_op;
                    w_issue_deq = !w_illegal && w_head_op;
                end
            end
            // The head seen during the deq pulse is the entry being removed.
            S_ISSUE: w_cap_rsp = r_pq_deq;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pq_enq     <= 1'b0;
            r_pq_deq     <= 1'b0;
            r_pq_kvi     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_kv     <= '0;
            r_err_drop   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_pq_enq    <= w_issue_enq;
            r_pq_deq    <= w_issue_deq;
            r_rsp_valid <= w_cap_rsp;
            r_err_drop  <= w_drop;
            if (w_issue_enq) begin
                r_pq_kvi <= w_head_kv;
            end else if (w_issue_deq) begin
                r_pq_kvi <= '0;
            end
            if (w_cap_rsp) begin
                r_rsp_kv <= pq_kvo;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign pq_enq     = r_pq_enq;
    assign pq_deq     = r_pq_deq;
    assign pq_kvi     = r_pq_kvi;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_kv     = r_rsp_kv;
    assign err_drop   = r_err_drop;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Scoreboard bench for pq_cmd_sequencer with directed command sequences.
// Expected PQ-side events are queued at stimulus time and popped by a monitor.
module tb_pq_cmd_sequencer;
    localparam int KW = 4;
    localparam int VW = 4;
    localparam int W  = KW + VW;

    localparam logic [1:0] EV_ENQ  = 2'd0;
    localparam logic [1:0] EV_DEQ  = 2'd1;
    localparam logic [1:0] EV_RSP  = 2'd2;
    localparam logic [1:0] EV_DROP = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pq_enq;
    logic         pq_deq;
    logic [W-1:0] pq_kvi;
    logic [W-1:0] pq_kvo;
    logic         pq_busy;
    logic         pq_full;
    logic         pq_empty;
    logic         rsp_valid;
    logic [W-1:0] rsp_kv;
    logic         err_drop;
    logic [7:0]   drop_count;

    always #5 clk = ~clk;

    pq_cmd_sequencer_if #(.KW(KW), .VW(VW)) cif ();

    pq_cmd_sequencer #(.KW(KW), .VW(VW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cif),
        .pq_enq     (pq_enq),
        .pq_deq     (pq_deq),
        .pq_kvi     (pq_kvi),
        .pq_kvo     (pq_kvo),
        .pq_busy    (pq_busy),
        .pq_full    (pq_full),
        .pq_empty   (pq_empty),
        .rsp_valid  (rsp_valid),
        .rsp_kv     (rsp_kv),
        .err_drop   (err_drop),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] kv;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] kv);
        ev_t e;
        e.kind = kind;
        e.kv   = kv;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic op, input logic [7:0] kv);
        int n;
        n = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_kv    = kv;
        while (!cif.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL push_timeout actual=ready_low required=accept");
            cif.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic [1:0] k;
        logic [7:0] v;
        ev_t        e;
        if (!rst) begin
            if (pq_enq && pq_deq) begin
                checks++;
                fails++;
                $display("FAIL enq_deq_both actual=11 required=one_hot");
            end else if (pq_enq || pq_deq || rsp_valid || err_drop) begin
                k = pq_enq ? EV_ENQ : pq_deq ? EV_DEQ :
                    rsp_valid ? EV_RSP : EV_DROP;
                v = (pq_enq || pq_deq) ? pq_kvi : rsp_valid ? rsp_kv : 8'h00;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event actual=kind%0d kv=%0h required=none",
                             k, v);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    if (k != EV_DROP) begin
                        chk("event_kv", 32'(v), 32'(e.kv));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 1'b0;
        cif.cmd_kv    = '0;
        pq_busy  = 1'b0;
        pq_full  = 1'b0;
        pq_empty = 1'b0;
        pq_kvo   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst0_ready", 32'(cif.cmd_ready), 1);
        chk("rst0_outs", 32'({pq_enq, pq_deq, rsp_valid, err_drop}), 0);

        // Reset while in WAIT with three commands queued.
        expect_ev(EV_ENQ, 8'h11);
        push(1'b0, 8'h11);
        @(negedge clk);
        pq_busy = 1'b1;
        push(1'b0, 8'h22);
        push(1'b0, 8'h33);
        push(1'b1, 8'h00);
        rst = 1'b1;
        #1;
        chk("t1_rst_ctl", 32'({pq_enq, pq_deq, rsp_valid, err_drop}), 0);
        chk("t1_rst_kvi", 32'(pq_kvi), 0);
        chk("t1_rst_rsp", 32'(rsp_kv), 0);
        chk("t1_rst_cnt", 32'(drop_count), 0);
        @(negedge clk);
        rst = 1'b0;
        pq_busy = 1'b0;
        @(negedge clk);
        chk("t1_ready", 32'(cif.cmd_ready), 1);
        repeat (10) @(negedge clk);

        // Enq 0x35 latency, then deq returning the head.
        expect_ev(EV_ENQ, 8'h35);
        push(1'b0, 8'h35);
        chk("t2_n1_enq", 32'(pq_enq), 0);
        @(negedge clk);
        chk("t2_n2_enq", 32'(pq_enq), 1);
        chk("t2_n2_kvi", 32'(pq_kvi), 32'h35);
        repeat (4) @(negedge clk);
        pq_kvo = 8'h35;
        expect_ev(EV_DEQ, 8'h00);
        expect_ev(EV_RSP, 8'h35);
        push(1'b1, 8'h00);
        repeat (6) @(negedge clk);

        // Deq into empty PQ is dropped; following enq still issues.
        pq_empty = 1'b1;
        pq_kvo   = 8'h00;
        expect_ev(EV_DROP, 8'h00);
        expect_ev(EV_ENQ, 8'hA7);
        push(1'b1, 8'h00);
        push(1'b0, 8'hA7);
        repeat (6) @(negedge clk);
        chk("t3_drop_count", 32'(drop_count), 1);
        pq_empty = 1'b0;

        // FIFO fills while PQ is busy; order kept after release.
        pq_busy = 1'b1;
        expect_ev(EV_ENQ, 8'h81);
        expect_ev(EV_ENQ, 8'h92);
        expect_ev(EV_ENQ, 8'hA3);
        expect_ev(EV_ENQ, 8'hB4);
        expect_ev(EV_ENQ, 8'hC5);
        push(1'b0, 8'h81);
        push(1'b0, 8'h92);
        push(1'b0, 8'hA3);
        push(1'b0, 8'hB4);
        chk("t4_full_ready", 32'(cif.cmd_ready), 0);
        fork
            push(1'b0, 8'hC5);
            begin
                repeat (3) @(negedge clk);
                pq_busy = 1'b0;
            end
        join
        repeat (20) @(negedge clk);

        // Busy held through WAIT; reissue two cycles after it falls.
        expect_ev(EV_ENQ, 8'h5C);
        expect_ev(EV_ENQ, 8'h6D);
        push(1'b0, 8'h5C);
        @(negedge clk);
        chk("t5_first_enq", 32'(pq_enq), 1);
        pq_busy = 1'b1;
        push(1'b0, 8'h6D);
        repeat (5) @(negedge clk);
        pq_busy = 1'b0;
        @(negedge clk);
        chk("t5_hold", 32'(pq_enq), 0);
        @(negedge clk);
        chk("t5_reissue", 32'(pq_enq), 1);
        chk("t5_kvi", 32'(pq_kvi), 32'h6D);
        repeat (6) @(negedge clk);

        // 256 illegal deqs saturate the drop counter.
        pq_empty = 1'b1;
        for (int i = 0; i < 256; i++) begin
            expect_ev(EV_DROP, 8'h00);
            push(1'b1, 8'h00);
        end
        repeat (10) @(negedge clk);
        chk("t6_drop_sat", 32'(drop_count), 255);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
